tt_um_accelshark_psg_i2s_rx: RTL and testbench

TT_UM_ACCELSHARK_PSG_I2S_RX -- requirements
Module: tt_um_accelshark_psg_i2s_rx

---
 rtl/tt_um_accelshark_psg_pkg.sv | 15 +
 rtl/tt_um_accelshark_psg_sync.sv | 36 +++
 rtl/tt_um_accelshark_psg_i2s_rx.sv | 132 +++++++++++++
 tb/tb_tt_um_accelshark_psg_i2s_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_accelshark_psg_pkg.sv
// Shared definitions for the accelshark PSG audio blocks.
//   PSG_SAMPLE_WIDTH : default sample width shared by receiver and transmitter
//   i2s_state_t      : I2S framing states (SYNC, LEFT, RIGHT)
`timescale 1ns/1ps
package tt_um_accelshark_psg_pkg;

  localparam int unsigned PSG_SAMPLE_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_t;

endpackage

// File: rtl/tt_um_accelshark_psg_sync.sv
// N-stage synchronizer for one asynchronous input, with registered
// rising-edge detect on the synchronized level.
//   clk   : system clock
//   rst_n : synchronous active-low reset (all flops to 0)
//   d     : asynchronous input
//   q     : synchronized level
//   rise  : one-cycle pulse, registered, after a 0->1 of q
`timescale 1ns/1ps
module tt_um_accelshark_psg_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
      q_d   <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~q_d;
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/tt_um_accelshark_psg_i2s_rx.sv
// I2S receiver: captures WIDTH-bit left/right words (MSB first, one-bit
// delay after word select changes) and presents them as stereo pairs.
//   clk, rst_n     : system clock, synchronous active-low reset
//   ena            : design enable; low freezes all state
//   sclk/lrck/sdata: asynchronous I2S bit clock, word select, data
//   sample_l/_r    : last completed left/right words
//   valid          : one-cycle pulse when a new stereo pair is presented
//   short_err      : one-cycle pulse when a committed word had < WIDTH bits
//   locked         : high after the first channel boundary since reset
`timescale 1ns/1ps
module tt_um_accelshark_psg_i2s_rx
  import tt_um_accelshark_psg_pkg::*;
#(
  parameter int unsigned WIDTH       = PSG_SAMPLE_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sclk,
  input  logic             lrck,
  input  logic             sdata,
  output logic [WIDTH-1:0] sample_l,
  output logic [WIDTH-1:0] sample_r,
  output logic             valid,
  output logic             short_err,
  output logic             locked
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic sclk_s_unused, sclk_rise;
  logic lrck_s, lrck_rise_unused;
  logic sdata_s, sdata_rise_unused;

  tt_um_accelshark_psg_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s_unused), .rise(sclk_rise)
  );
  tt_um_accelshark_psg_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk(clk), .rst_n(rst_n), .d(lrck), .q(lrck_s), .rise(lrck_rise_unused)
  );
  tt_um_accelshark_psg_sync #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(clk), .rst_n(rst_n), .d(sdata), .q(sdata_s), .rise(sdata_rise_unused)
  );

  i2s_state_t       state, state_next;
  logic             prev_ws, prev_vld;
  logic             have_left;
  logic [WIDTH-1:0] shift_reg, staging, word_in;
  logic [CNT_W-1:0] bit_cnt, cnt_in;
  logic             ev, boundary, short_in;

  assign ev       = ena & sclk_rise;
  // The first edge after reset has no predecessor, so it cannot be a boundary.
  assign boundary = prev_vld & (lrck_s != prev_ws);

  // Bits land directly at their left-justified position, so a short word
  // already has zeros in its low bits; bits past WIDTH are dropped.
  always_comb begin
    word_in = shift_reg;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bit_cnt == CNT_W'(WIDTH - 1 - i)) word_in[i] = sdata_s;
    end
    cnt_in   = (bit_cnt == CNT_W'(WIDTH)) ? bit_cnt : bit_cnt + CNT_W'(1);
    short_in = (cnt_in != CNT_W'(WIDTH));
  end

  always_comb begin
    state_next = state;
    if (ev && boundary) begin
      case (state)
        ST_SYNC:  state_next = lrck_s ? ST_RIGHT : ST_LEFT;
        ST_LEFT:  state_next = ST_RIGHT;
        ST_RIGHT: state_next = ST_LEFT;
        default:  state_next = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_ws   <= 1'b0;
      prev_vld  <= 1'b0;
      have_left <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      staging   <= '0;
      sample_l  <= '0;
      sample_r  <= '0;
      valid     <= 1'b0;
      short_err <= 1'b0;
      locked    <= 1'b0;
    end else begin
      valid     <= 1'b0;
      short_err <= 1'b0;
      if (ev) begin
        prev_ws  <= lrck_s;
        prev_vld <= 1'b1;
        if (state == ST_SYNC) begin
          if (boundary) begin
            locked    <= 1'b1;
            have_left <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end else if (boundary) begin
          // The boundary bit is the last bit of the word being closed.
          short_err <= short_in;
          shift_reg <= '0;
          bit_cnt   <= '0;
          if (state == ST_LEFT) begin
            staging   <= word_in;
            have_left <= 1'b1;
          end else if (have_left) begin
            sample_r <= word_in;
            sample_l <= staging;
            valid    <= 1'b1;
          end
        end else begin
          shift_reg <= word_in;
          bit_cnt   <= cnt_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_um_accelshark_psg_i2s_rx.sv
`timescale 1ns/1ps
module tb_tt_um_accelshark_psg_i2s_rx;

  typedef struct packed {
    logic [7:0] l;
    logic [7:0] r;
  } pair_t;

  logic       clk, rst_n, ena, sclk, lrck, sdata;
  logic [7:0] sample_l, sample_r;
  logic       valid, short_err, locked;

  int    checks = 0;
  int    errors = 0;
  int    valid_cnt = 0;
  int    short_cnt = 0;
  pair_t exp_q[$];

  tt_um_accelshark_psg_i2s_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sclk(sclk), .lrck(lrck),
    .sdata(sdata), .sample_l(sample_l), .sample_r(sample_r),
    .valid(valid), .short_err(short_err), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Expected 8-bit capture of an n-bit MSB-first word: truncate or left-justify.
  function automatic logic [7:0] exp8(input logic [15:0] w, input int n);
    logic [15:0] t;
    if (n >= 8) t = w >> (n - 8);
    else        t = w << (8 - n);
    return t[7:0];
  endfunction

  // One sclk period = 8 clk periods; data/ws change with the falling edge.
  task automatic send_bit(input logic ws, input logic sd);
    sclk = 1'b0; lrck = ws; sdata = sd;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Last bit goes out with the next channel's word select (I2S one-bit delay).
  task automatic send_word(input logic ch, input logic [15:0] w, input int n, input logic next_ch);
    for (int b = n - 1; b >= 1; b--) send_bit(ch, w[b]);
    send_bit(next_ch, w[0]);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n, input bit expect_valid);
    send_word(1'b0, l, n, 1'b1);
    if (expect_valid) exp_q.push_back('{l: exp8(l, n), r: exp8(r, n)});
    send_word(1'b1, r, n, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sclk = 1'b0; lrck = 1'b0; sdata = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rst_l"}, {24'd0, sample_l}, 32'h0);
    chk({tag, "_rst_r"}, {24'd0, sample_r}, 32'h0);
    chk({tag, "_rst_valid"}, {31'd0, valid}, 32'h0);
    chk({tag, "_rst_short"}, {31'd0, short_err}, 32'h0);
    chk({tag, "_rst_locked"}, {31'd0, locked}, 32'h0);
  endtask

  // Junk right-channel bits, then a boundary into left: locks the receiver.
  task automatic preamble();
    send_word(1'b1, 16'h0, 2, 1'b0);
  endtask

  initial begin
    int vbase, sbase;
    logic [7:0] pat;
    ena = 1'b1; rst_n = 1'b0; sclk = 1'b0; lrck = 1'b0; sdata = 1'b0;

    fork
      forever begin
        pair_t e;
        @(negedge clk);
        if (short_err) short_cnt++;
        if (valid) begin
          valid_cnt++;
          checks++;
          assert (exp_q.size() > 0)
            else begin
              errors++;
              $error("FAIL unexpected_valid observed=%0h/%0h expected=no_valid", sample_l, sample_r);
            end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pair_l", {24'd0, sample_l}, {24'd0, e.l});
            chk("pair_r", {24'd0, sample_r}, {24'd0, e.r});
          end
        end
      end
    join_none

    // 8-bit frames A5/3C
    do_reset();
    chk_reset_state("t8");
    vbase = valid_cnt; sbase = short_cnt;
    preamble();
    chk("t8_locked", {31'd0, locked}, 32'h1);
    send_frame(16'h00A5, 16'h003C, 8, 1'b1);
    send_frame(16'h00A5, 16'h003C, 8, 1'b1);
    repeat (8) @(negedge clk);
    chk("t8_l", {24'd0, sample_l}, 32'hA5);
    chk("t8_r", {24'd0, sample_r}, 32'h3C);
    chk("t8_valid_cnt", valid_cnt - vbase, 32'd2);
    chk("t8_short_cnt", short_cnt - sbase, 32'd0);

    // 16-bit words truncated
    do_reset();
    vbase = valid_cnt; sbase = short_cnt;
    preamble();
    send_frame(16'h1234, 16'hABCD, 16, 1'b1);
    send_frame(16'h1234, 16'hABCD, 16, 1'b1);
    repeat (8) @(negedge clk);
    chk("t16_l", {24'd0, sample_l}, 32'h12);
    chk("t16_r", {24'd0, sample_r}, 32'hAB);
    chk("t16_valid_cnt", valid_cnt - vbase, 32'd2);
    chk("t16_short_cnt", short_cnt - sbase, 32'd0);

    // 4-bit words left-justified, short_err at every commit
    do_reset();
    vbase = valid_cnt; sbase = short_cnt;
    preamble();
    send_frame(16'h000B, 16'h0006, 4, 1'b1);
    send_frame(16'h000B, 16'h0006, 4, 1'b1);
    repeat (8) @(negedge clk);
    chk("t4_l", {24'd0, sample_l}, 32'hB0);
    chk("t4_r", {24'd0, sample_r}, 32'h60);
    chk("t4_valid_cnt", valid_cnt - vbase, 32'd2);
    chk("t4_short_cnt", short_cnt - sbase, 32'd4);

    // Constant lrck: never locks
    do_reset();
    vbase = valid_cnt;
    pat = 8'hA5;
    for (int i = 0; i < 64; i++) send_bit(1'b0, pat[7 - (i % 8)]);
    repeat (8) @(negedge clk);
    chk("nolock_locked", {31'd0, locked}, 32'h0);
    chk("nolock_valid_cnt", valid_cnt - vbase, 32'd0);
    chk("nolock_l", {24'd0, sample_l}, 32'h0);
    chk("nolock_r", {24'd0, sample_r}, 32'h0);

    // Reset in the middle of a left word
    do_reset();
    vbase = valid_cnt;
    preamble();
    send_frame(16'h00A5, 16'h003C, 8, 1'b1);
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_state("midrst");
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1);
    chk("midrst_relock", {31'd0, locked}, 32'h1);
    send_word(1'b1, 16'h003C, 8, 1'b0);
    repeat (8) @(negedge clk);
    chk("midrst_no_early_valid", valid_cnt - vbase, 32'd1);
    chk("midrst_hold_l", {24'd0, sample_l}, 32'h0);
    send_frame(16'h00A5, 16'h003C, 8, 1'b1);
    repeat (8) @(negedge clk);
    chk("midrst_valid_cnt", valid_cnt - vbase, 32'd2);
    chk("midrst_l", {24'd0, sample_l}, 32'hA5);
    chk("midrst_r", {24'd0, sample_r}, 32'h3C);

    // ena low across one whole frame
    do_reset();
    preamble();
    send_frame(16'h00A5, 16'h003C, 8, 1'b1);
    repeat (4) @(negedge clk);
    vbase = valid_cnt;
    ena = 1'b0;
    send_frame(16'h0011, 16'h0022, 8, 1'b0);
    repeat (8) @(negedge clk);
    chk("ena_valid_cnt", valid_cnt - vbase, 32'd0);
    chk("ena_hold_l", {24'd0, sample_l}, 32'hA5);
    chk("ena_hold_r", {24'd0, sample_r}, 32'h3C);
    ena = 1'b1;
    send_frame(16'h005A, 16'h00C3, 8, 1'b1);
    repeat (8) @(negedge clk);
    chk("ena_after_valid_cnt", valid_cnt - vbase, 32'd1);
    chk("ena_after_l", {24'd0, sample_l}, 32'h5A);
    chk("ena_after_r", {24'd0, sample_r}, 32'hC3);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
